mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency main memory between the fetch-stage instruction port and the memory-stage data port.
- Arbitrates between the two ports and issues one access at a time.
- Counts the memory latency and returns the result with a one-cycle done pulse.
- Data port has priority; an aging counter guarantees the instruction port cannot starve.

Parameters:
- LAT, 4: memory read/write latency in cycles from accepted issue to mem_rdata valid (>=1).
- MAX_WAIT, 8: cycles the instruction port may be denied before it gets forced priority (>=1).
- AW, 16: address width.
- DW, 16: data width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- i_req  input  1  instruction read request, held until i_done.
- i_addr  input  AW  instruction address, stable while i_req.
- i_done  output  1  one-cycle pulse, instruction read complete.
- i_rdata  output  DW  instruction read data, valid with i_done, held afterwards.
- d_req  input  1  data request, held until d_done.
- d_wr  input  1  1 = write, 0 = read; stable while d_req.
- d_addr  input  AW  data address.
- d_wdata  input  DW  write data.
- d_done  output  1  one-cycle pulse, data access complete.
- d_rdata  output  DW  data read data, valid with d_done on reads.
- mem_rd  output  1  memory read issue.
- mem_wr  output  1  memory write issue.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_stall  input  1  memory cannot accept an issue this cycle.
- mem_rdata  input  DW  memory read data, valid LAT cycles after accepted issue.
- busy  output  1  access outstanding (state != IDLE).
- err  output  1  sticky protocol error.

Behaviour:
- States:
  - IDLE: no access outstanding; arbitration happens here.
  - BUSY_I, BUSY_D: an access is outstanding for that port.
  - DONE_I, DONE_D: one cycle; the matching done output is asserted.
- Reset (rst = 0, asynchronous):
  - state IDLE; latency counter, wait counter and err cleared.
  - All outputs 0: done pulses, mem_rd/mem_wr, mem_addr, mem_wdata, i_rdata, d_rdata, busy.
- Arbitration (IDLE only, combinational):
  - Winner is D if d_req and not (i_req and wait_cnt == MAX_WAIT).
  - Otherwise the winner is I if i_req.
  - Winner's command drives mem_rd/mem_wr/mem_addr/mem_wdata in the same cycle; mem_wdata = d_wdata for D writes, else 0.
  - mem_rd/mem_wr are asserted only in IDLE with a winner.
- Issue acceptance:
  - Accepted when mem_rd|mem_wr and !mem_stall.
  - On accept: go to BUSY_x, load lat_cnt = LAT-1.
  - With mem_stall: remain in IDLE and re-arbitrate next cycle, so the winner may change.
- BUSY_x:
  - No memory commands; lat_cnt decrements each cycle.
  - In the cycle lat_cnt == 0 (issue cycle + LAT):
    - Capture mem_rdata into i_rdata (BUSY_I) or d_rdata (BUSY_D read). A D write leaves d_rdata unchanged.
    - Go to DONE_x.
- DONE_x:
  - Matching done = 1 for exactly this cycle; next state IDLE.
  - Requester drops req or presents a new request in the following cycle.
  - Done lands at issue + LAT + 1.
  - Back-to-back throughput: one access per LAT + 2 cycles.
- wait_cnt (saturating at MAX_WAIT):
  - Increments in any cycle with i_req = 1 where I is not accepted.
  - Clears when I is accepted or i_req = 0.
- err is set (sticky until reset) when:
  - a request arrives with an odd address (addr[0] = 1) at arbitration; the request is still serviced with addr[0] forced to 0;
  - the owning req drops while BUSY_x/DONE_x is pending (the access completes and its done still pulses);
  - done fires for a port whose req is low.
- Simultaneous events:
  - New requests arriving during BUSY/DONE wait for IDLE.
  - Both requests in IDLE → D wins unless I has aged to MAX_WAIT.
- Reset mid-access: outstanding access is abandoned, no done is produced, and a late mem_rdata is ignored.

Test Plan:
- Single I read, LAT = 4: i_req = 1, i_addr = 0x0010, mem_rdata = 0xBEEF at issue + 4 → mem_rd = 1 in cycle 0, i_done = 1 in cycle 5 with i_rdata = 0xBEEF, busy = 1 in cycles 1–5.
- Simultaneous requests: i_req = d_req = 1, d_wr = 1, d_addr = 0x0100, d_wdata = 0x1234 → mem_wr = 1 with mem_addr 0x0100 and mem_wdata 0x1234 first, d_done at cycle 5; I issues at cycle 6, i_done at cycle 11.
- Starvation: d_req held continuously with back-to-back new requests, i_req held, MAX_WAIT = 8 → wait_cnt reaches 8, and the next IDLE arbitration grants I despite d_req = 1.
- mem_stall held 3 cycles with a D read pending → mem_rd held for 3 cycles, issue accepted in the 4th cycle, d_done exactly LAT + 1 cycles after acceptance.
- Protocol errors: i_addr = 0x0011 → mem_addr = 0x0010, err = 1 and stays 1; separately, d_req dropped during BUSY_D → err = 1 and d_done still pulses.
- Reset (rst = 0) asserted during BUSY_I, released 2 cycles later → all outputs 0 immediately, no i_done, state IDLE, err = 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency, single-ported memory between an instruction read port
// and a data read/write port; data wins unless the instruction port has aged out.
module mem_port_arbiter #(
    parameter int LAT      = 4,
    parameter int MAX_WAIT = 8,
    parameter int AW       = 16,
    parameter int DW       = 16,
    localparam int WW      = $clog2(MAX_WAIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_stall,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          err,
    output logic [2:0]    dbgState,
    output logic [WW-1:0] dbgWaitCnt
);

    localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_t;

    state_t        state;
    logic [LW-1:0] latCnt;
    logic [WW-1:0] waitCnt;
    logic          curWr;
    logic          grantD;
    logic          grantI;
    logic          accept;
    logic          oddAddr;
    logic          dropErr;
    logic          doneErr;
    logic          iAged;

    assign iAged = i_req && (waitCnt == WW'(MAX_WAIT));

    // Arbitration is combinational and only live in IDLE; reset gates it so every
    // memory command reads 0 while rst is low.
    always_comb begin
        grantD = 1'b0;
        grantI = 1'b0;
        if (rst && state == IDLE) begin
            if (d_req && !iAged) begin
                grantD = 1'b1;
            end else if (i_req) begin
                grantI = 1'b1;
            end
        end
    end

    assign mem_rd    = grantI | (grantD & ~d_wr);
    assign mem_wr    = grantD & d_wr;
    assign mem_addr  = grantD ? {d_addr[AW-1:1], 1'b0} :
                       grantI ? {i_addr[AW-1:1], 1'b0} : '0;
    assign mem_wdata = (grantD && d_wr) ? d_wdata : '0;
    assign accept    = (mem_rd | mem_wr) & ~mem_stall;

    assign oddAddr = (grantD & d_addr[0]) | (grantI & i_addr[0]);
    assign dropErr = ((state == BUSY_I || state == DONE_I) && !i_req) ||
                     ((state == BUSY_D || state == DONE_D) && !d_req);
    assign doneErr = (i_done && !i_req) || (d_done && !d_req);

    assign busy       = (state != IDLE);
    assign dbgState   = state;
    assign dbgWaitCnt = waitCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            latCnt  <= '0;
            waitCnt <= '0;
            curWr   <= 1'b0;
            err     <= 1'b0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;

            if (oddAddr || dropErr || doneErr) begin
                err <= 1'b1;
            end

            // Aging counts every denied cycle, including while another access is in flight.
            if (!i_req || (grantI && accept)) begin
                waitCnt <= '0;
            end else if (waitCnt != WW'(MAX_WAIT)) begin
                waitCnt <= waitCnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= grantD ? BUSY_D : BUSY_I;
                        curWr  <= grantD & d_wr;
                        latCnt <= LW'(LAT - 1);
                    end
                end
                BUSY_I: begin
                    if (latCnt == '0) begin
                        i_rdata <= mem_rdata;
                        i_done  <= 1'b1;
                        state   <= DONE_I;
                    end else begin
                        latCnt <= latCnt - 1'b1;
                    end
                end
                BUSY_D: begin
                    if (latCnt == '0) begin
                        if (!curWr) begin
                            d_rdata <= mem_rdata;
                        end
                        d_done <= 1'b1;
                        state  <= DONE_D;
                    end else begin
                        latCnt <= latCnt - 1'b1;
                    end
                end
                DONE_I, DONE_D: state <= IDLE;
                default:        state <= IDLE;
            endcase
        end
    end

endmodule
